sound_dsm_dac: RTL and testbench

//  Audio output stage between the PLANET_EMP sound generator and the P43/P44 pin pair.

---
 rtl/sound_dsm_dac_if.sv | 21 ++
 rtl/sound_dsm_dac.sv | 167 ++++++++++++++++
 tb/tb_sound_dsm_dac.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_dsm_dac_if.sv
// Sample stream into the DSM DAC: signed PCM word with valid/ready handshake.
// A word transfers on a clock edge where SMPL_VLD_i and SMPL_RDY_o are both high.
interface sound_dsm_dac_if #(
    parameter int C_W = 16
);
    logic [C_W-1:0] SMPL_i;
    logic           SMPL_VLD_i;
    logic           SMPL_RDY_o;

    modport master (
        output SMPL_i,
        output SMPL_VLD_i,
        input  SMPL_RDY_o
    );

    modport slave (
        input  SMPL_i,
        input  SMPL_VLD_i,
        output SMPL_RDY_o
    );
endinterface

// File: rtl/sound_dsm_dac.sv
// Audio output: sample FIFO, fractional-rate sample tick, 2nd-order delta-sigma to 1 bit.
// Define SOUND_DSM_DITHER_EN to add LFSR dither (-2..+1 LSB) ahead of the first integrator.
module sound_dsm_dac #(
    parameter int C_F_CK       = 135_000_000,
    parameter int C_F_SMPL     = 48_000,
    parameter int C_W          = 16,
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_DSM_DIV    = 8
) (
    input  logic           CK_i,
    input  logic           RST_i,
    sound_dsm_dac_if.slave smpl_if,
    output logic           SOUND_o,
    output logic           XSOUND_o,
    output logic           UNDERRUN_o,
    output logic           TICK_o
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int PW = $clog2(C_F_CK) + 1;
    localparam int IW = C_W + 4;
    localparam int SW = C_W + 6;
    localparam int DW = (C_DSM_DIV > 1) ? $clog2(C_DSM_DIV) : 1;

    localparam logic [PW-1:0] P_STEP = PW'(C_F_SMPL);
    localparam logic [PW-1:0] P_MOD  = PW'(C_F_CK);
    localparam logic [AW:0]   F_LVL  = (AW + 1)'(C_FIFO_DEPTH);
    localparam logic [DW-1:0] D_LAST = DW'(C_DSM_DIV - 1);

    localparam logic signed [SW-1:0] FB_POS  = SW'(64'sd1 <<< (C_W - 1));
    localparam logic signed [SW-1:0] FB_NEG  = -FB_POS;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (IW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(64'sd1 <<< (IW - 1)));

    function automatic logic signed [IW-1:0] sat(
        input logic signed [SW-1:0] v
    );
        logic signed [IW-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[IW-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[IW-1:0];
        end else begin
            r = v[IW-1:0];
        end
        return r;
    endfunction

    // sample FIFO
    logic [C_W-1:0] mem_q [C_FIFO_DEPTH];
    logic [AW:0]    wr_q;
    logic [AW:0]    rd_q;
    logic [AW:0]    wr_d;
    logic [AW:0]    rd_d;
    logic           rdy_q;
    logic           empty;
    logic           full_d;
    logic           push;
    logic           pop;

    // sample tick
    logic [PW-1:0]  phase_q;
    logic [PW-1:0]  phase_sum;
    logic           tick_hit;

    // modulator
    logic [C_W-1:0]        hold_q;
    logic [DW-1:0]         div_q;
    logic                  upd;
    logic signed [IW-1:0]  dith;
    logic signed [IW-1:0]  x;
    logic signed [IW-1:0]  i1_q;
    logic signed [IW-1:0]  i2_q;
    logic signed [IW-1:0]  i1_d;
    logic signed [IW-1:0]  i2_d;
    logic signed [SW-1:0]  fb;
    logic signed [SW-1:0]  s1;
    logic signed [SW-1:0]  s2;

    assign smpl_if.SMPL_RDY_o = rdy_q;

    assign empty  = (wr_q == rd_q);
    assign push   = smpl_if.SMPL_VLD_i && rdy_q;
    // a pop on a tick sees the FIFO before this edge's push lands
    assign pop    = TICK_o && !empty;
    assign wr_d   = wr_q + (AW + 1)'(push);
    assign rd_d   = rd_q + (AW + 1)'(pop);
    assign full_d = ((wr_d - rd_d) == F_LVL);

    assign phase_sum = phase_q + P_STEP;
    assign tick_hit  = (phase_sum >= P_MOD);

    assign upd = (div_q == D_LAST);

    always_ff @(posedge CK_i) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= smpl_if.SMPL_i;
        end
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            wr_q       <= '0;
            rd_q       <= '0;
            rdy_q      <= 1'b0;
            phase_q    <= '0;
            TICK_o     <= 1'b0;
            UNDERRUN_o <= 1'b0;
            hold_q     <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rdy_q      <= !full_d;
            phase_q    <= tick_hit ? (phase_sum - P_MOD) : phase_sum;
            TICK_o     <= tick_hit;
            UNDERRUN_o <= TICK_o && empty;
            if (pop) begin
                hold_q <= mem_q[rd_q[AW-1:0]];
            end
        end
    end

`ifdef SOUND_DSM_DITHER_EN
    logic [15:0] lfsr_q;

    assign dith = {{(IW - 1){lfsr_q[0]}}, lfsr_q[1]};

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            lfsr_q <= 16'hACE1;
        end else if (upd) begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    assign dith = '0;
`endif

    // sums run two bits wider than the integrators so clamping never sees a wrap
    always_comb begin
        x    = {{(IW - C_W){hold_q[C_W-1]}}, hold_q} + dith;
        fb   = SOUND_o ? FB_POS : FB_NEG;
        s1   = SW'(i1_q) + SW'(x) - fb;
        i1_d = sat(s1);
        s2   = SW'(i2_q) + SW'(i1_d) - fb;
        i2_d = sat(s2);
    end

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            div_q    <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            SOUND_o  <= 1'b0;
            XSOUND_o <= 1'b1;
        end else if (upd) begin
            div_q    <= '0;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            SOUND_o  <= !i2_d[IW-1];
            XSOUND_o <= i2_d[IW-1];
        end else begin
            div_q    <= div_q + DW'(1);
        end
    end

endmodule

// File: tb/tb_sound_dsm_dac.sv
// Randomized bench for sound_dsm_dac against a per-cycle behavioural model.
// Clock/sample ratio is scaled down so rate checks stay short.
`timescale 1ns/1ps
module tb_sound_dsm_dac;

    localparam int F_CK   = 2700;
    localparam int F_SMPL = 48;
    localparam int W      = 16;
    localparam int DEPTH  = 4;
    localparam int DIV    = 2;
    localparam int PER    = (F_CK + F_SMPL - 1) / F_SMPL;
    localparam longint HALF = 64'sd1 <<< (W - 1);
    localparam longint IMAX = (64'sd1 <<< (W + 3)) - 1;
    localparam longint IMIN = -(64'sd1 <<< (W + 3));
`ifdef SOUND_DSM_DITHER_EN
    localparam int TOL = 40;
`else
    localparam int TOL = 2;
`endif

    logic CK_i  = 1'b0;
    logic RST_i = 1'b1;
    logic SOUND_o;
    logic XSOUND_o;
    logic UNDERRUN_o;
    logic TICK_o;

    sound_dsm_dac_if #(.C_W(W)) sif ();

    sound_dsm_dac #(
        .C_F_CK      (F_CK),
        .C_F_SMPL    (F_SMPL),
        .C_W         (W),
        .C_FIFO_DEPTH(DEPTH),
        .C_DSM_DIV   (DIV)
    ) dut (
        .CK_i      (CK_i),
        .RST_i     (RST_i),
        .smpl_if   (sif.slave),
        .SOUND_o   (SOUND_o),
        .XSOUND_o  (XSOUND_o),
        .UNDERRUN_o(UNDERRUN_o),
        .TICK_o    (TICK_o)
    );

    always #5 CK_i = ~CK_i;

    int n_vec = 0;
    int n_err = 0;

    longint q[$];
    longint m_n;
    longint m_hold;
    longint m_i1;
    longint m_i2;
    bit     m_tick;
    bit     m_und;
    bit     m_rdy;
    bit     m_snd;
`ifdef SOUND_DSM_DITHER_EN
    logic [15:0] m_lfsr;
`endif
    bit acc;
    bit upd;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v);
        return (v > IMAX) ? IMAX : ((v < IMIN) ? IMIN : v);
    endfunction

    // a tick is due whenever n*Fs/Fck crosses another integer
    function automatic bit tick_at(input longint n);
        return ((n * F_SMPL) / F_CK) != (((n - 1) * F_SMPL) / F_CK);
    endfunction

    task automatic model_reset();
        q.delete();
        m_n    = 0;
        m_hold = 0;
        m_i1   = 0;
        m_i2   = 0;
        m_tick = 0;
        m_und  = 0;
        m_rdy  = 0;
        m_snd  = 0;
`ifdef SOUND_DSM_DITHER_EN
        m_lfsr = 16'hACE1;
`endif
    endtask

    task automatic cycle(input bit rst, input bit vld, input logic [W-1:0] d);
        longint x;
        longint fb;
        bit     und;
        RST_i          = rst;
        sif.SMPL_VLD_i = vld;
        sif.SMPL_i     = d;
        @(posedge CK_i);
        acc = 0;
        upd = 0;
        if (rst) begin
            model_reset();
        end else begin
            m_n++;
            if (m_n % DIV == 0) begin
                x  = m_hold;
                fb = m_snd ? HALF : -HALF;
`ifdef SOUND_DSM_DITHER_EN
                x += m_lfsr[0] ? (m_lfsr[1] ? -1 : -2) : (m_lfsr[1] ? 1 : 0);
                m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
                m_i1  = clamp(m_i1 + x - fb);
                m_i2  = clamp(m_i2 + m_i1 - fb);
                m_snd = (m_i2 >= 0);
                upd   = 1;
            end
            und = 0;
            if (m_tick) begin
                if (q.size() > 0) m_hold = q.pop_front();
                else und = 1;
            end
            if (vld && m_rdy) begin
                q.push_back(longint'($signed(d)));
                acc = 1;
            end
            m_und  = und;
            m_rdy  = (q.size() < DEPTH);
            m_tick = tick_at(m_n);
        end
        #1;
        chk("tick", TICK_o, m_tick);
        chk("underrun", UNDERRUN_o, m_und);
        chk("rdy", sif.SMPL_RDY_o, m_rdy);
        chk("sound", SOUND_o, m_snd);
        chk("xsound", XSOUND_o, !m_snd);
    endtask

    task automatic do_reset(input int k);
        repeat (k) cycle(1'b1, 1'b0, '0);
    endtask

    task automatic run_updates(input int n, output int ones);
        ones = 0;
        for (int k = 0; k < n; ) begin
            cycle(1'b0, 1'b0, '0);
            if (upd) begin
                k++;
                ones += int'(SOUND_o);
            end
        end
    endtask

    // push one sample into an empty FIFO and run until a tick pops it
    task automatic load_hold(input logic [W-1:0] v, input string tag);
        int g;
        g = 0;
        acc = 0;
        while (!acc && g < 8) begin
            cycle(1'b0, 1'b1, v);
            g++;
        end
        chk({tag, "_push"}, acc, 1);
        g = 0;
        while (!TICK_o && g < 2 * PER) begin
            cycle(1'b0, 1'b0, '0);
            g++;
        end
        chk({tag, "_tick"}, TICK_o, 1);
        cycle(1'b0, 1'b0, '0);
    endtask

    initial begin
        int ticks;
        int first;
        int unds;
        int acc_n;
        int idx;
        int g;
        int ones;
        int want;
        logic [W-1:0] smp [6];

        sif.SMPL_i     = '0;
        sif.SMPL_VLD_i = 1'b0;

        do_reset(3);
        chk("rst_sound", SOUND_o, 0);
        chk("rst_xsound", XSOUND_o, 1);
        chk("rst_rdy", sif.SMPL_RDY_o, 0);
        chk("rst_tick", TICK_o, 0);
        chk("rst_underrun", UNDERRUN_o, 0);

        ticks = 0;
        first = 0;
        for (int i = 1; i <= F_CK; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (i == 1) chk("rdy_after_rst", sif.SMPL_RDY_o, 1);
            if (TICK_o) begin
                ticks++;
                if (first == 0) first = i;
            end
        end
        chk("rate_first_tick", first, PER);
        chk("rate_tick_count", ticks, F_SMPL);

        do_reset(3);
        for (int i = 0; i < 6; i++) smp[i] = W'($urandom);
        acc_n = 0;
        idx   = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, smp[idx]);
            if (acc) begin
                acc_n++;
                idx++;
            end
        end
        chk("bp_accepted", acc_n, DEPTH);
        chk("bp_rdy_full", sif.SMPL_RDY_o, 0);
        g = 0;
        while (!TICK_o && g < 2 * PER) begin
            cycle(1'b0, 1'b1, smp[idx]);
            g++;
        end
        chk("bp_tick_seen", TICK_o, 1);
        cycle(1'b0, 1'b1, smp[idx]);
        chk("bp_rdy_after_tick", sif.SMPL_RDY_o, 1);
        cycle(1'b0, 1'b1, smp[idx]);
        chk("bp_fifth_accepted", acc, 1);

        do_reset(3);
        chk("midrst_sound", SOUND_o, 0);
        chk("midrst_xsound", XSOUND_o, 1);
        cycle(1'b0, 1'b0, '0);
        chk("midrst_rdy", sif.SMPL_RDY_o, 1);
        g = 0;
        while (!TICK_o && g < 2 * PER) begin
            cycle(1'b0, 1'b0, '0);
            g++;
        end
        cycle(1'b0, 1'b0, '0);
        chk("midrst_fifo_empty", UNDERRUN_o, 1);

        do_reset(3);
        g = 0;
        acc = 0;
        while (!acc && g < 8) begin
            cycle(1'b0, 1'b1, 16'h4000);
            g++;
        end
        chk("ur_push", acc, 1);
        ticks = 0;
        unds  = 0;
        g     = 0;
        while (ticks < 3 && g < 4 * PER) begin
            cycle(1'b0, 1'b0, '0);
            ticks += int'(TICK_o);
            unds  += int'(UNDERRUN_o);
            g++;
        end
        cycle(1'b0, 1'b0, '0);
        unds += int'(UNDERRUN_o);
        chk("ur_ticks", ticks, 3);
        chk("ur_pulses", unds, 2);

        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset(int'($urandom_range(1, 3)));
            cycle(1'b0, $urandom_range(0, 39) == 0, W'($urandom));
        end

        do_reset(3);
        run_updates(8000, ones);
        want = 8000 * (0 + 32768) / 65536;
        chk("dens_mid_in_tol", (ones >= want - TOL) && (ones <= want + TOL), 1);

        load_hold(16'h4000, "dens_q");
        run_updates(8000, ones);
        want = 8000 * (16384 + 32768) / 65536;
        chk("dens_3q_in_tol", (ones >= want - TOL) && (ones <= want + TOL), 1);

        load_hold(16'h8000, "dens_min");
        run_updates(16, ones);
        run_updates(64, ones);
        chk("dens_min_ones", ones, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
